// File: rtl/keccak_theta_folded.sv
// Plane-serial Keccak theta step. Five planes are loaded one per beat while the
// column parities build up, one cycle turns the parities into the D words, and
// the five result planes are then drained one per beat.

// One lane column x. It forms D[x] from the neighbouring column parities and
// mixes D[x] into the buffered lane that is currently being drained.
module keccak_theta_lane #(
  parameter int LANE_W = 64
) (
  input  logic [LANE_W-1:0] c_m1,      // C[(x+4)%5]
  input  logic [LANE_W-1:0] c_p1,      // C[(x+1)%5]
  input  logic [LANE_W-1:0] d_lane,    // registered D[x]
  input  logic [LANE_W-1:0] buf_lane,  // buffered lane (x, y)
  input  logic              bypass_q,
  output logic [LANE_W-1:0] d_nxt,
  output logic [LANE_W-1:0] out_lane
);
  logic [LANE_W-1:0] rot;

  // Rotate left by one inside the lane. A one-bit lane rotates onto itself.
  generate
    if (LANE_W == 1) begin : g_rot1
      assign rot = c_p1;
    end else begin : g_rotn
      assign rot = {c_p1[LANE_W-2:0], c_p1[LANE_W-1]};
    end
  endgenerate

  assign d_nxt    = c_m1 ^ rot;
  assign out_lane = bypass_q ? buf_lane : (buf_lane ^ d_lane);
endmodule

module keccak_theta_folded #(
  parameter int LANE_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5*LANE_W-1:0]   in_plane,
  input  logic                  bypass,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [5*LANE_W-1:0]   out_plane,
  output logic                  out_last,
  output logic                  busy
);
  typedef enum logic [1:0] {LOAD, CALC, DRAIN} state_t;

  state_t                         state_q, state_d;
  logic [2:0]                     y_q, y_d;
  logic [4:0][LANE_W-1:0]         lane_in, lane_out;
  logic [4:0][LANE_W-1:0]         c_q, d_q, d_nxt;
  logic [4:0][4:0][LANE_W-1:0]    pbuf_q;
  logic                           bypass_q;
  logic                           in_xfer, out_xfer;

  // The packed lane view lines up with the plane bus: lane x at [x*LANE_W +: LANE_W].
  assign lane_in  = in_plane;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // State and plane counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      y_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
    end
  end

  // Next-state logic and the handshake outputs. Loading and draining never overlap.
  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_xfer) begin
          if (y_q == 3'd4) begin
            state_d = CALC;
            y_d     = 3'd0;
          end else begin
            y_d = y_q + 3'd1;
          end
        end
      end
      CALC: state_d = DRAIN;
      DRAIN: begin
        out_valid = 1'b1;
        if (out_xfer) begin
          if (y_q == 3'd4) begin
            state_d = LOAD;
            y_d     = 3'd0;
          end else begin
            y_d = y_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = LOAD;
        y_d     = 3'd0;
      end
    endcase
  end

  // Plane buffer, running column parity, bypass latch and D words.
  // Parity restarts on plane 0 so a new state never mixes with the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pbuf_q   <= '0;
      c_q      <= '0;
      d_q      <= '0;
      bypass_q <= 1'b0;
    end else begin
      if (in_xfer) begin
        pbuf_q[y_q] <= lane_in;
        c_q         <= (y_q == 3'd0) ? lane_in : (c_q ^ lane_in);
        if (y_q == 3'd0) bypass_q <= bypass;
      end
      if (state_q == CALC) d_q <= d_nxt;
    end
  end

  // Per-column theta datapath.
  generate
    for (genvar x = 0; x < 5; x++) begin : g_lane
      keccak_theta_lane #(.LANE_W(LANE_W)) u_lane (
        .c_m1     (c_q[(x+4)%5]),
        .c_p1     (c_q[(x+1)%5]),
        .d_lane   (d_q[x]),
        .buf_lane (pbuf_q[y_q][x]),
        .bypass_q (bypass_q),
        .d_nxt    (d_nxt[x]),
        .out_lane (lane_out[x])
      );
    end
  endgenerate

  // Output plane is forced to zero whenever nothing is being offered.
  assign out_plane = out_valid ? lane_out : '0;
  assign out_last  = out_valid && (y_q == 3'd4);
  assign busy      = (state_q != LOAD) || (y_q != 3'd0);
endmodule

// File: tb/tb_keccak_theta_folded.sv
// Randomised bench for keccak_theta_folded at lane widths 64, 8, 16 and 1,
// checked against a plain theta model over a 5x5 lane array.
module tb_keccak_theta_folded;
  typedef logic [24:0][63:0] st_t;   // lane (x,y) at index 5*y+x

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int sel   = 0;

  logic [4:0][63:0] lanes = '0;
  logic [4:0][63:0] obs;
  logic iv_g = 1'b0, ordy_g = 1'b0, byp = 1'b0;
  logic [3:0] iv, ir, ov, ol, bz;
  logic [319:0] ip64, op64;
  logic [39:0]  ip8, op8;
  logic [79:0]  ip16, op16;
  logic [4:0]   ip1, op1;

  keccak_theta_folded #(.LANE_W(64)) u_d64 (.clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_plane(ip64), .bypass(byp), .out_valid(ov[0]), .out_ready(ordy_g), .out_plane(op64), .out_last(ol[0]), .busy(bz[0]));
  keccak_theta_folded #(.LANE_W(8)) u_d8 (.clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_plane(ip8), .bypass(byp), .out_valid(ov[1]), .out_ready(ordy_g), .out_plane(op8), .out_last(ol[1]), .busy(bz[1]));
  keccak_theta_folded #(.LANE_W(16)) u_d16 (.clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_plane(ip16), .bypass(byp), .out_valid(ov[2]), .out_ready(ordy_g), .out_plane(op16), .out_last(ol[2]), .busy(bz[2]));
  keccak_theta_folded #(.LANE_W(1)) u_d1 (.clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
    .in_plane(ip1), .bypass(byp), .out_valid(ov[3]), .out_ready(ordy_g), .out_plane(op1), .out_last(ol[3]), .busy(bz[3]));

  // Route the shared stimulus to every width and pick the selected DUT's output.
  always_comb begin
    iv = 4'b0;
    if (iv_g) iv[sel] = 1'b1;
    obs = '0;
    for (int x = 0; x < 5; x++) begin
      ip64[x*64 +: 64] = lanes[x];
      ip16[x*16 +: 16] = lanes[x][15:0];
      ip8[x*8 +: 8]    = lanes[x][7:0];
      ip1[x]           = lanes[x][0];
      case (sel)
        0: obs[x]       = op64[x*64 +: 64];
        1: obs[x][7:0]  = op8[x*8 +: 8];
        2: obs[x][15:0] = op16[x*16 +: 16];
        default: obs[x][0] = op1[x];
      endcase
    end
  end

  task automatic chk(input string tag, input logic [319:0] o, input logic [319:0] e);
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, o, e);
    end
  endtask

  function automatic int wof(input int k);
    case (k)
      0: return 64;
      1: return 8;
      2: return 16;
      default: return 1;
    endcase
  endfunction

  function automatic logic [63:0] msk(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // theta: C[x] = xor of column x; D[x] = C[x-1] ^ rol(C[x+1],1); A'[x][y] = A[x][y] ^ D[x].
  function automatic st_t ref_theta(input st_t a, input int w, input bit b);
    logic [63:0] c[5];
    logic [63:0] d[5];
    logic [63:0] m;
    st_t r;
    m = msk(w);
    for (int x = 0; x < 5; x++) begin
      c[x] = '0;
      for (int y = 0; y < 5; y++) c[x] ^= a[5*y+x];
    end
    for (int x = 0; x < 5; x++)
      d[x] = c[(x+4)%5] ^ (((c[(x+1)%5] << 1) | (c[(x+1)%5] >> (w-1))) & m);
    for (int i = 0; i < 25; i++) r[i] = b ? a[i] : (a[i] ^ d[i%5]);
    return r;
  endfunction

  function automatic st_t rand_state(input int w);
    st_t a;
    for (int i = 0; i < 25; i++) a[i] = {$urandom, $urandom} & msk(w);
    return a;
  endfunction

  function automatic logic [319:0] plane_of(input st_t s, input int y);
    logic [4:0][63:0] p;
    for (int x = 0; x < 5; x++) p[x] = s[5*y+x];
    return p;
  endfunction

  // Push one state, drain it and check every offered plane. abort_y >= 0 pulses reset
  // when that output plane is offered; timing checks the no-stall cadence.
  task automatic run_state(input st_t a, input bit b0, input bit b1, input bit rnd,
                           input int abort_y, input bit timing);
    int   w = wof(sel);
    st_t  e;
    int   y, guard;
    int   t_in0 = 0, t_in4 = 0, t_out0 = 0, t_last = 0;
    e = ref_theta(a, w, b0);
    for (y = 0; y < 5; y++) begin
      if (rnd) repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        iv_g = 1'b0;
        lanes = {5{$urandom, $urandom}};
      end
      @(negedge clk);
      iv_g = 1'b1;
      byp = (y < 2) ? b0 : b1;
      for (int x = 0; x < 5; x++) lanes[x] = a[5*y+x];
      chk("in_ready_load", 320'(ir[sel]), 320'(1));
      if (y == 1) chk("busy_load", 320'(bz[sel]), 320'(1));
      if (y == 0) t_in0 = cyc;
      if (y == 4) t_in4 = cyc;
    end
    @(negedge clk);
    iv_g = 1'b0;
    byp = ~b0;
    chk("calc_in_ready", 320'(ir[sel]), 320'(0));
    chk("calc_out_valid", 320'(ov[sel]), 320'(0));
    y = 0;
    guard = 0;
    while (y < 5 && guard < 200) begin
      @(negedge clk);
      guard++;
      ordy_g = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      iv_g = rnd ? 1'($urandom_range(0, 1)) : 1'b0;   // must be ignored outside LOAD
      lanes = {5{$urandom, $urandom}};
      chk("drain_in_ready", 320'(ir[sel]), 320'(0));
      if (ov[sel]) begin
        if (abort_y == y) begin
          rst_n = 1'b0;
          #1;
          chk("abort_out_valid", 320'(ov[sel]), 320'(0));
          chk("abort_in_ready", 320'(ir[sel]), 320'(1));
          chk("abort_busy", 320'(bz[sel]), 320'(0));
          chk("abort_out_plane", obs, 320'(0));
          iv_g = 1'b0;
          ordy_g = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        chk($sformatf("plane_y%0d", y), obs, plane_of(e, y));
        chk("out_last", 320'(ol[sel]), 320'(y == 4));
        if (ordy_g) begin
          if (y == 0) t_out0 = cyc;
          if (y == 4) t_last = cyc;
          y++;
        end
      end
    end
    if (guard >= 200) chk("drain_timeout", 320'(y), 320'(5));
    @(negedge clk);
    iv_g = 1'b0;
    ordy_g = 1'b0;
    chk("post_in_ready", 320'(ir[sel]), 320'(1));
    chk("post_busy", 320'(bz[sel]), 320'(0));
    chk("post_out_valid", 320'(ov[sel]), 320'(0));
    if (timing) begin
      chk("latency", 320'(t_out0 - t_in4), 320'(2));
      chk("cadence", 320'(t_last - t_in0), 320'(10));
    end
  endtask

  initial begin
    st_t a;
    int  ks[3] = '{0, 2, 3};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 320'(ir[0]), 320'(1));
    chk("rst_out_valid", 320'(ov[0]), 320'(0));
    chk("rst_out_plane", obs, 320'(0));
    chk("rst_out_last", 320'(ol[0]), 320'(0));
    chk("rst_busy", 320'(bz[0]), 320'(0));
    rst_n = 1'b1;

    // all-zero state, cadence
    sel = 0;
    a = '0;
    run_state(a, 1'b0, 1'b0, 1'b0, -1, 1'b1);
    // single bit in lane (0,0)
    a = '0;
    a[0] = 64'h1;
    run_state(a, 1'b0, 1'b0, 1'b0, -1, 1'b1);
    // rotate wrap at 8-bit lanes, lane (2,0) = 0x80
    sel = 1;
    a = '0;
    a[2] = 64'h80;
    run_state(a, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    // bypass latched on plane 0 only, both directions
    sel = 0;
    run_state(rand_state(64), 1'b1, 1'b0, 1'b0, -1, 1'b0);
    run_state(rand_state(64), 1'b0, 1'b1, 1'b0, -1, 1'b0);
    sel = 1;
    run_state(rand_state(8), 1'b1, 1'b0, 1'b1, -1, 1'b0);
    // random states, stalls and gaps over several widths
    for (int n = 0; n < 100; n++) begin
      sel = ks[$urandom_range(0, 2)];
      run_state(rand_state(wof(sel)), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                1'b1, -1, 1'b0);
    end
    // reset during drain, then a clean state afterwards
    sel = 0;
    run_state(rand_state(64), 1'b0, 1'b0, 1'b0, 2, 1'b0);
    run_state(rand_state(64), 1'b0, 1'b0, 1'b0, -1, 1'b1);
    sel = 2;
    run_state(rand_state(16), 1'b0, 1'b0, 1'b1, 4, 1'b0);
    run_state(rand_state(16), 1'b0, 1'b0, 1'b1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d want=0", 1);
    $fatal(1);
  end
endmodule
